spike_threshold_unit: RTL and testbench
=======================================

# spike_threshold_unit

Post-leak neuron stage. It takes each neuron's leaked membrane potential from `VmemLeakUnit` (Q32.32) and applies refractory hold, threshold compare and reset. It writes the updated Vmem and refractory count back to neuron status memory and queues the IDs of spiking neurons in an internal FIFO for the spike router. It is a 2-stage pipeline with valid/ready input and a first-word-fall-through spike FIFO output.

## Interface
Parameters:
- `INTEGER_WIDTH`, 32: integer bits of Vmem and of the integer-only inputs.
- `DATA_WIDTH_FRAC`, 32: fractional bits of Vmem.
- `DATA_WIDTH`, `INTEGER_WIDTH+DATA_WIDTH_FRAC`: full Vmem width.
- `NEURON_ID_WIDTH`, 8: neuron index width.
- `REFRAC_WIDTH`, 8: refractory counter width.
- `SPIKE_FIFO_DEPTH`, 16: spike FIFO entries. Must be a power of two and at least 4.

Ports:
- `Clock`, in, 1: single clock. All state updates on the rising edge.
- `Reset`, in, 1: synchronous, active-low.
- `StepStart`, in, 1: one-cycle pulse at the start of a timestep. Clears `StepSpikeCount`.
- `InValid`, in, 1: input beat valid.
- `InReady`, out, 1: unit accepts a beat this cycle.
- `NeuronId`, in, `NEURON_ID_WIDTH`: neuron being processed.
- `VmemIn`, in, signed `DATA_WIDTH`: leaked Vmem from the leak unit.
- `RefracIn`, in, `REFRAC_WIDTH`: remaining refractory cycles from status memory.
- `Vth`, in, signed `INTEGER_WIDTH`: threshold (integer).
- `Vreset`, in, signed `INTEGER_WIDTH`: reset potential (integer).
- `RefracPeriod`, in, `REFRAC_WIDTH`: refractory load value on spike.
- `WbValid`, out, 1: write-back beat. No backpressure.
- `WbNeuronId`, out, `NEURON_ID_WIDTH`: write-back address.
- `WbVmem`, out, signed `DATA_WIDTH`: updated Vmem.
- `WbRefrac`, out, `REFRAC_WIDTH`: updated refractory count.
- `WbSpike`, out, 1: the written neuron spiked.
- `SpikeValid`, out, 1: FIFO non-empty.
- `SpikeId`, out, `NEURON_ID_WIDTH`: FIFO head (FWFT).
- `SpikeReady`, in, 1: consumer pops the head.
- `StepSpikeCount`, out, 32: spikes since the last `StepStart`.
- `Overflow`, out, 1: sticky flag. A spike was dropped on a full FIFO.

## Operation
- Accept a beat when `InValid && InReady`.
- Stage 1 registers `NeuronId`, `VmemIn`, `RefracIn`, `Vth`, `Vreset` and `RefracPeriod`, and computes:
  - `VthExt = {Vth, 0^FRAC}`
  - `VresetExt = {Vreset, 0^FRAC}`
- Stage 2 decision, in priority order:
  1. `RefracIn != 0` → `WbVmem = VresetExt`, `WbRefrac = RefracIn-1`, no spike. The threshold is ignored.
  2. Else if signed `VmemIn >= VthExt` → spike: `WbVmem = VresetExt`, `WbRefrac = RefracPeriod`, `WbSpike = 1`, push `NeuronId` to the FIFO, increment `StepSpikeCount`.
  3. Else → `WbVmem = VmemIn`, `WbRefrac = 0`, `WbSpike = 0`.
- The compare is a full-width signed compare. Exact equality spikes.
- `RefracPeriod = 0` on a spike gives `WbRefrac = 0`, so the neuron is eligible again next timestep.
- Flow control: `InReady = (fifo_count + inflight_spikes_possible) < SPIKE_FIFO_DEPTH`.
  - `inflight_spikes_possible` counts valid stage-1 and stage-2 entries.
  - The pipeline never stalls internally. Accepted beats always retire.
  - Overflow is therefore unreachable in legal use. If a push still hits a full FIFO, the ID is dropped, `Overflow` is set, and the write-back still occurs.
- FIFO rules:
  - Push and pop in the same cycle: count unchanged, both take effect.
  - Pop when empty: ignored.
  - Pointers wrap modulo `SPIKE_FIFO_DEPTH`.
- `StepSpikeCount`:
  - `StepStart` in the same cycle as a spike: count becomes 1, not 0.
  - Saturates at `2^32-1`.
- Reset (`Reset == 0`): both pipeline stages invalidated, FIFO emptied, counters cleared, `Overflow` cleared.
  - Beats in flight are lost. Upstream must re-issue the timestep.

## Timing
- Latency: beat accepted at edge N → `WbValid` asserted in the cycle after edge N+2, i.e. the beat appears in the write-back registers at N+2.
- Throughput: 1 beat/cycle while `InReady` stays high.
- Spike visibility: a pushed ID is visible on `SpikeId`/`SpikeValid` one cycle after its `WbValid` cycle.
- `InReady` is combinational from registered state only. It has no path from `InValid` or `SpikeReady`.
- Reset values:
  - `InReady = 1`
  - `WbValid = 0`, `WbNeuronId = 0`, `WbVmem = 0`, `WbRefrac = 0`, `WbSpike = 0`
  - `SpikeValid = 0`, `SpikeId = 0`
  - `StepSpikeCount = 0`, `Overflow = 0`
- `Wb*` data fields hold their last value while `WbValid = 0`.

## Test plan
- **Below threshold.** Vth=10, Vreset=0, `VmemIn`=9.5 (0x9_80000000), `RefracIn`=0 → 3 cycles later `WbVmem`=0x9_80000000, `WbRefrac`=0, `WbSpike`=0, FIFO empty.
- **Equality spike.** `VmemIn`=10.0, Vth=10, Vreset=-2, `RefracPeriod`=5, `NeuronId`=7 → `WbVmem`=0xFFFFFFFE_00000000, `WbRefrac`=5, `WbSpike`=1; next cycle `SpikeValid`=1, `SpikeId`=7; `StepSpikeCount`=1.
- **Refractory hold.** `RefracIn`=3, `VmemIn`=50.0, Vth=10 → `WbRefrac`=2, `WbVmem`=`VresetExt`, no spike.
- **Back-pressure.** 20 consecutive spiking beats (IDs 0..19), `SpikeReady`=0, depth 16 → `InReady` drops once 16 spikes are queued or in flight; exactly 16 IDs (0..15) are stored; `Overflow` stays 0. Then `SpikeReady`=1 → IDs pop in order 0..15 and `InReady` recovers.
- **Simultaneous events.** `StepStart` in the same cycle as a spike retire → `StepSpikeCount`=1. Push and pop in the same cycle with count 4 → count stays 4.
- **Reset mid-stream.** `Reset`=0 with 2 beats in flight and 3 FIFO entries → the next cycle has `WbValid`=0, `SpikeValid`=0, `StepSpikeCount`=0, `InReady`=1; the in-flight beats never emerge.

Source files
------------

// File: rtl/spike_threshold_unit.sv
`timescale 1ns/1ps
// Post-leak neuron stage: refractory hold, threshold compare and reset, with write-back
// to status memory and a first-word-fall-through FIFO of spiking neuron IDs.
module spike_threshold_unit #(
  parameter int INTEGER_WIDTH    = 32,
  parameter int DATA_WIDTH_FRAC  = 32,
  parameter int DATA_WIDTH       = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int NEURON_ID_WIDTH  = 8,
  parameter int REFRAC_WIDTH     = 8,
  parameter int SPIKE_FIFO_DEPTH = 16
) (
  input  logic                              Clock,
  input  logic                              Reset,
  input  logic                              StepStart,
  input  logic                              InValid,
  output logic                              InReady,
  input  logic [NEURON_ID_WIDTH-1:0]        NeuronId,
  input  logic signed [DATA_WIDTH-1:0]      VmemIn,
  input  logic [REFRAC_WIDTH-1:0]           RefracIn,
  input  logic signed [INTEGER_WIDTH-1:0]   Vth,
  input  logic signed [INTEGER_WIDTH-1:0]   Vreset,
  input  logic [REFRAC_WIDTH-1:0]           RefracPeriod,
  output logic                              WbValid,
  output logic [NEURON_ID_WIDTH-1:0]        WbNeuronId,
  output logic signed [DATA_WIDTH-1:0]      WbVmem,
  output logic [REFRAC_WIDTH-1:0]           WbRefrac,
  output logic                              WbSpike,
  output logic                              SpikeValid,
  output logic [NEURON_ID_WIDTH-1:0]        SpikeId,
  input  logic                              SpikeReady,
  output logic [31:0]                       StepSpikeCount,
  output logic                              Overflow
);

  localparam int PTR_W = $clog2(SPIKE_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  // Handshake: a beat transfers on a rising edge where InValid && InReady; upstream holds the
  // beat stable until then. The spike FIFO pops on SpikeValid && SpikeReady. WbValid has no ready.
  logic                          w_accept;
  logic                          w_push_req, w_push, w_pop, w_full;
  logic [OCC_W-1:0]              w_occupancy;

  logic                          r_s1_valid;
  logic [NEURON_ID_WIDTH-1:0]    r_s1_id;
  logic signed [DATA_WIDTH-1:0]  r_s1_vmem, r_s1_vth_ext, r_s1_vreset_ext;
  logic [REFRAC_WIDTH-1:0]       r_s1_refrac, r_s1_period;

  logic                          r_s2_valid, r_s2_hold, r_s2_ge;
  logic [NEURON_ID_WIDTH-1:0]    r_s2_id;
  logic signed [DATA_WIDTH-1:0]  r_s2_vmem, r_s2_vreset_ext;
  logic [REFRAC_WIDTH-1:0]       r_s2_refrac, r_s2_period;

  logic                          r_wb_valid, r_wb_spike;
  logic [NEURON_ID_WIDTH-1:0]    r_wb_id;
  logic signed [DATA_WIDTH-1:0]  r_wb_vmem;
  logic [REFRAC_WIDTH-1:0]       r_wb_refrac;

  logic [NEURON_ID_WIDTH-1:0]    r_mem [SPIKE_FIFO_DEPTH];
  logic [PTR_W-1:0]              r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]              r_count;
  logic [31:0]                   r_step_cnt;
  logic                          r_overflow;

  // Every beat in the pipe may still spike, so reserving a FIFO slot per beat makes overflow
  // impossible without any internal stall.
  assign w_occupancy = OCC_W'(r_count) + OCC_W'(r_s1_valid) + OCC_W'(r_s2_valid)
                     + OCC_W'(r_wb_valid);
  assign InReady     = w_occupancy < OCC_W'(SPIKE_FIFO_DEPTH);
  assign w_accept    = InValid && InReady;

  always_ff @(posedge Clock) begin
    if (!Reset) r_s1_valid <= 1'b0;
    else        r_s1_valid <= w_accept;
    if (w_accept) begin
      r_s1_id         <= NeuronId;
      r_s1_vmem       <= VmemIn;
      r_s1_refrac     <= RefracIn;
      r_s1_vth_ext    <= {Vth, {DATA_WIDTH_FRAC{1'b0}}};
      r_s1_vreset_ext <= {Vreset, {DATA_WIDTH_FRAC{1'b0}}};
      r_s1_period     <= RefracPeriod;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) r_s2_valid <= 1'b0;
    else        r_s2_valid <= r_s1_valid;
    if (r_s1_valid) begin
      r_s2_id         <= r_s1_id;
      r_s2_vmem       <= r_s1_vmem;
      r_s2_refrac     <= r_s1_refrac;
      r_s2_vreset_ext <= r_s1_vreset_ext;
      r_s2_period     <= r_s1_period;
      r_s2_hold       <= (r_s1_refrac != '0);
      r_s2_ge         <= (r_s1_vmem >= r_s1_vth_ext);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_wb_valid  <= 1'b0;
      r_wb_id     <= '0;
      r_wb_vmem   <= '0;
      r_wb_refrac <= '0;
      r_wb_spike  <= 1'b0;
    end else begin
      r_wb_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_wb_id <= r_s2_id;
        if (r_s2_hold) begin
          r_wb_vmem   <= r_s2_vreset_ext;
          r_wb_refrac <= r_s2_refrac - REFRAC_WIDTH'(1);
          r_wb_spike  <= 1'b0;
        end else if (r_s2_ge) begin
          r_wb_vmem   <= r_s2_vreset_ext;
          r_wb_refrac <= r_s2_period;
          r_wb_spike  <= 1'b1;
        end else begin
          r_wb_vmem   <= r_s2_vmem;
          r_wb_refrac <= '0;
          r_wb_spike  <= 1'b0;
        end
      end
    end
  end

  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign w_full     = (r_count == CNT_W'(SPIKE_FIFO_DEPTH));
  assign w_pop      = SpikeReady && (r_count != '0);
  assign w_push_req = r_wb_valid && r_wb_spike;
  assign w_push     = w_push_req && (!w_full || w_pop);

  always_ff @(posedge Clock) begin
    if (w_push) r_mem[r_wr_ptr] <= r_wb_id;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_step_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_push_req && !w_push) r_overflow <= 1'b1;
      if (StepStart)                               r_step_cnt <= {31'd0, w_push_req};
      else if (w_push_req && (r_step_cnt != '1))   r_step_cnt <= r_step_cnt + 32'd1;
    end
  end

  assign WbValid        = r_wb_valid;
  assign WbNeuronId     = r_wb_id;
  assign WbVmem         = r_wb_vmem;
  assign WbRefrac       = r_wb_refrac;
  assign WbSpike        = r_wb_spike;
  assign SpikeValid     = (r_count != '0);
  assign SpikeId        = SpikeValid ? r_mem[r_rd_ptr] : '0;
  assign StepSpikeCount = r_step_cnt;
  assign Overflow       = r_overflow;

endmodule

// File: tb/tb_spike_threshold_unit.sv
`timescale 1ns/1ps
// Directed and randomised checks of spike_threshold_unit against an arithmetic reference
// model of the threshold rules, the spike FIFO contents and the per-step spike count.
module tb_spike_threshold_unit;
  localparam int     IW    = 32;
  localparam int     DW    = 64;
  localparam int     NW    = 8;
  localparam int     RW    = 8;
  localparam int     DEPTH = 16;
  localparam longint SCALE = 64'sh1_0000_0000;

  typedef struct packed {
    logic [NW-1:0] id;
    logic [DW-1:0] vmem;
    logic [RW-1:0] refrac;
    logic          spike;
    int            edge_n;
  } wb_t;

  logic                 Clock = 1'b0, Reset = 1'b0, StepStart = 1'b0, InValid = 1'b0;
  logic                 SpikeReady = 1'b0, InReady;
  logic [NW-1:0]        NeuronId = '0;
  logic signed [DW-1:0] VmemIn = '0;
  logic [RW-1:0]        RefracIn = '0, RefracPeriod = '0;
  logic signed [IW-1:0] Vth = '0, Vreset = '0;
  logic                 WbValid, WbSpike, SpikeValid, Overflow;
  logic [NW-1:0]        WbNeuronId, SpikeId;
  logic signed [DW-1:0] WbVmem;
  logic [RW-1:0]        WbRefrac;
  logic [31:0]          StepSpikeCount;

  spike_threshold_unit dut (
    .Clock(Clock), .Reset(Reset), .StepStart(StepStart), .InValid(InValid), .InReady(InReady),
    .NeuronId(NeuronId), .VmemIn(VmemIn), .RefracIn(RefracIn), .Vth(Vth), .Vreset(Vreset),
    .RefracPeriod(RefracPeriod), .WbValid(WbValid), .WbNeuronId(WbNeuronId), .WbVmem(WbVmem),
    .WbRefrac(WbRefrac), .WbSpike(WbSpike), .SpikeValid(SpikeValid), .SpikeId(SpikeId),
    .SpikeReady(SpikeReady), .StepSpikeCount(StepSpikeCount), .Overflow(Overflow)
  );

  // clock / watchdog
  always #5 Clock = ~Clock;
  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // scoreboard state
  wb_t           exp_q[$];
  logic [NW-1:0] fifo_q[$];
  logic [NW-1:0] popped_q[$];
  logic [31:0]   m_cnt = '0;
  logic          m_ovf = 1'b0;
  wb_t           m_hold = '0;
  bit            m_push_pending = 1'b0;
  logic [NW-1:0] m_push_id = '0;
  bit            m_wb_live = 1'b0;
  int            cyc = 0, n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic wb_t ref_model(input logic [NW-1:0] id, input logic signed [DW-1:0] vmem,
                                    input logic [RW-1:0] refrac, input logic signed [IW-1:0] vth,
                                    input logic signed [IW-1:0] vreset,
                                    input logic [RW-1:0] period, input int edge_n);
    wb_t    r;
    longint v, th, rs;
    v  = longint'(vmem);
    th = longint'(vth) * SCALE;
    rs = longint'(vreset) * SCALE;
    r.id     = id;
    r.edge_n = edge_n;
    if (refrac != 0) begin
      r.vmem = rs; r.refrac = refrac - RW'(1); r.spike = 1'b0;
    end else if (v >= th) begin
      r.vmem = rs; r.refrac = period; r.spike = 1'b1;
    end else begin
      r.vmem = v; r.refrac = '0; r.spike = 1'b0;
    end
    return r;
  endfunction

  // One clock: record what the edge will do, advance, update the model, compare everything.
  task automatic step(output bit accepted);
    bit  pop_req, step_req, rst, pop, full;
    wb_t e;
    accepted = InValid && InReady && Reset;
    if (accepted)
      exp_q.push_back(ref_model(NeuronId, VmemIn, RefracIn, Vth, Vreset, RefracPeriod, cyc + 1));
    if (SpikeReady && SpikeValid) popped_q.push_back(SpikeId);
    pop_req  = SpikeReady;
    step_req = StepStart;
    rst      = Reset;
    @(posedge Clock);
    cyc++;
    #1;
    m_wb_live = 1'b0;
    if (!rst) begin
      exp_q.delete();
      fifo_q.delete();
      m_cnt = '0; m_ovf = 1'b0; m_hold = '0; m_push_pending = 1'b0;
      check("rst_wb_valid", WbValid, 0);
    end else begin
      full = (fifo_q.size() == DEPTH);
      pop  = pop_req && (fifo_q.size() != 0);
      if (pop) void'(fifo_q.pop_front());
      if (m_push_pending) begin
        if (!full || pop) fifo_q.push_back(m_push_id);
        else m_ovf = 1'b1;
      end
      if (step_req) m_cnt = m_push_pending ? 32'd1 : 32'd0;
      else if (m_push_pending && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      m_push_pending = 1'b0;
      if (WbValid) begin
        if (exp_q.size() == 0) check("wb_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("wb_latency", cyc, e.edge_n + 2);
          check("wb_id", WbNeuronId, e.id);
          check("wb_vmem", WbVmem, e.vmem);
          check("wb_refrac", WbRefrac, e.refrac);
          check("wb_spike", WbSpike, e.spike);
          m_hold = e; m_wb_live = 1'b1;
          m_push_pending = e.spike; m_push_id = e.id;
        end
      end else if (exp_q.size() != 0 && cyc >= exp_q[0].edge_n + 2) begin
        check("wb_missing", 0, 1);
        void'(exp_q.pop_front());
      end
    end
    if (!WbValid) begin
      check("hold_id", WbNeuronId, m_hold.id);
      check("hold_vmem", WbVmem, m_hold.vmem);
      check("hold_refrac", WbRefrac, m_hold.refrac);
      check("hold_spike", WbSpike, m_hold.spike);
    end
    check("spike_valid", SpikeValid, fifo_q.size() != 0);
    check("spike_id", SpikeId, (fifo_q.size() != 0) ? fifo_q[0] : '0);
    check("step_count", StepSpikeCount, m_cnt);
    check("overflow", Overflow, m_ovf);
    check("in_ready", InReady, (fifo_q.size() + exp_q.size() + int'(m_wb_live)) < DEPTH);
  endtask

  // driver tasks
  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  task automatic drive_beat(input logic [NW-1:0] id, input logic [DW-1:0] vmem,
                            input logic [RW-1:0] refrac, input logic [IW-1:0] vth,
                            input logic [IW-1:0] vreset, input logic [RW-1:0] period,
                            input int max_wait, output bit accepted);
    NeuronId = id; VmemIn = vmem; RefracIn = refrac;
    Vth = vth; Vreset = vreset; RefracPeriod = period;
    InValid  = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < max_wait && !accepted; i++) step(accepted);
    InValid = 1'b0;
  endtask

  task automatic send(input logic [NW-1:0] id, input logic [DW-1:0] vmem,
                      input logic [RW-1:0] refrac, input logic [IW-1:0] vth,
                      input logic [IW-1:0] vreset, input logic [RW-1:0] period);
    bit acc;
    drive_beat(id, vmem, refrac, vth, vreset, period, 60, acc);
    check("accept_timeout", acc, 1);
  endtask

  localparam logic [DW-1:0] V100 = 64'h0000_0064_0000_0000;

  initial begin
    bit acc, acc_last;
    int vth_i, delta;
    logic [31:0] frac;

    // reset
    Reset = 1'b0;
    idle(2);
    Reset = 1'b1;
    check("rst_in_ready", InReady, 1);
    check("rst_wb_vmem", WbVmem, 0);
    StepStart = 1'b1; idle(1); StepStart = 1'b0;

    // below threshold: 9.5 against 10
    send(8'd1, 64'h0000_0009_8000_0000, 0, 32'd10, 32'd0, 8'd3);
    idle(2);
    check("below_wb_valid", WbValid, 1);
    check("below_vmem", WbVmem, 64'h0000_0009_8000_0000);
    check("below_refrac", WbRefrac, 0);
    check("below_spike", WbSpike, 0);
    idle(1);
    check("below_fifo_empty", SpikeValid, 0);

    // exact equality spikes
    send(8'd7, 64'h0000_000A_0000_0000, 0, 32'd10, 32'hFFFF_FFFE, 8'd5);
    idle(2);
    check("eq_vmem", WbVmem, 64'hFFFF_FFFE_0000_0000);
    check("eq_refrac", WbRefrac, 5);
    check("eq_spike", WbSpike, 1);
    idle(1);
    check("eq_spike_valid", SpikeValid, 1);
    check("eq_spike_id", SpikeId, 7);
    check("eq_count", StepSpikeCount, 1);

    // refractory hold ignores the threshold
    send(8'd3, 64'h0000_0032_0000_0000, 8'd3, 32'd10, 32'hFFFF_FFFE, 8'd5);
    idle(2);
    check("refrac_refrac", WbRefrac, 2);
    check("refrac_vmem", WbVmem, 64'hFFFF_FFFE_0000_0000);
    check("refrac_spike", WbSpike, 0);

    SpikeReady = 1'b1; idle(3); SpikeReady = 1'b0;
    StepStart = 1'b1; idle(1); StepStart = 1'b0;

    // back-pressure: 16 spikes fill every slot, the 17th must wait
    for (int i = 0; i < 16; i++) send(NW'(i), V100, 0, 32'd10, 32'd0, 8'd0);
    drive_beat(8'd16, V100, 0, 32'd10, 32'd0, 8'd0, 10, acc);
    check("bp_stalled", acc, 0);
    check("bp_in_ready", InReady, 0);
    check("bp_overflow", Overflow, 0);
    check("bp_count", StepSpikeCount, 16);
    popped_q.delete();
    SpikeReady = 1'b1;
    for (int i = 16; i < 20; i++) send(NW'(i), V100, 0, 32'd10, 32'd0, 8'd0);
    idle(24);
    SpikeReady = 1'b0;
    check("bp_pop_count", popped_q.size(), 20);
    for (int i = 0; i < 20 && i < popped_q.size(); i++) check("bp_pop_order", popped_q[i], i);
    check("bp_in_ready_back", InReady, 1);

    // StepStart coinciding with a spike retire
    send(8'd9, V100, 0, 32'd10, 32'd0, 8'd0);
    idle(2);
    StepStart = 1'b1; idle(1); StepStart = 1'b0;
    check("sim_step_count", StepSpikeCount, 1);

    // push and pop together with four entries queued
    SpikeReady = 1'b1; idle(2); SpikeReady = 1'b0;
    for (int i = 0; i < 4; i++) send(NW'(40 + i), V100, 0, 32'd10, 32'd0, 8'd0);
    idle(4);
    send(8'd50, V100, 0, 32'd10, 32'd0, 8'd0);
    idle(2);
    SpikeReady = 1'b1; idle(1); SpikeReady = 1'b0;
    popped_q.delete();
    SpikeReady = 1'b1; idle(8); SpikeReady = 1'b0;
    check("pp_pop_count", popped_q.size(), 4);
    if (popped_q.size() == 4) check("pp_last_id", popped_q[3], 50);

    // reset with three queued spikes and two beats in flight
    for (int i = 0; i < 3; i++) send(NW'(60 + i), V100, 0, 32'd10, 32'd0, 8'd0);
    idle(4);
    send(8'd63, V100, 0, 32'd10, 32'd0, 8'd0);
    send(8'd64, V100, 0, 32'd10, 32'd0, 8'd0);
    Reset = 1'b0; idle(1); Reset = 1'b1;
    check("rstm_wb_valid", WbValid, 0);
    check("rstm_spike_valid", SpikeValid, 0);
    check("rstm_count", StepSpikeCount, 0);
    check("rstm_in_ready", InReady, 1);
    idle(5);

    // randomised traffic around the threshold
    acc_last = 1'b0;
    for (int n = 0; n < 700; n++) begin
      if (!InValid || acc_last) begin
        vth_i = int'($urandom_range(0, 40)) - 20;
        delta = int'($urandom_range(0, 4)) - 2;
        frac  = ($urandom_range(0, 1) == 1) ? 32'd0 : $urandom;
        Vth          = vth_i;
        VmemIn       = longint'(vth_i + delta) * SCALE + longint'(frac);
        Vreset       = int'($urandom_range(0, 10)) - 5;
        RefracIn     = ($urandom_range(0, 2) == 0) ? RW'($urandom_range(1, 6)) : '0;
        RefracPeriod = RW'($urandom_range(0, 6));
        NeuronId     = NW'($urandom);
        InValid      = ($urandom_range(0, 3) != 0);
      end
      SpikeReady = ($urandom_range(0, 2) != 0);
      StepStart  = ($urandom_range(0, 19) == 0);
      step(acc_last);
    end
    InValid = 1'b0; StepStart = 1'b0; SpikeReady = 1'b1;
    idle(20);
    check("drain_empty", exp_q.size(), 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
